bin2bcd_seq: RTL

Sequential binary-to-BCD converter between the meteo acquisition datapath (compensated temperature/pressure/humidity words) and the six 7-segment digit decoders on the DE0-CV board. It accepts one DATA_W-bit value per request, optionally two's-complement, and converts it to six packed BCD digits with shift-and-add-3 (double dabble), one bit per clock. Magnitudes above 999999 are clamped, and negative values are reported through a separate sign flag for the display minus segment.

---
 rtl/bin2bcd_pkg.sv | 22 ++
 rtl/bin2bcd_seq_if.sv | 36 +++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t    : FSM state encoding (IDLE/PREP/SHIFT/DONE)
//   NDIG       : number of packed BCD digits produced
//   BCD_MAX    : largest value representable in NDIG digits (clamp level)
//   MAX_DATA_W : widest supported input word
//   CNT_W      : width of the shift iteration counter
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PREP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NDIG       = 6;
    localparam int BCD_MAX    = 999999;
    localparam int MAX_DATA_W = 20;
    localparam int CNT_W      = $clog2(MAX_DATA_W + 1);

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
// Request/result bundle between a client and bin2bcd_seq.
//   Start_i  : conversion request (client -> converter)
//   Data_i   : DATA_W-bit binary value
//   Signed_i : 1 = Data_i is two's complement
//   Busy_o   : conversion in progress
//   Done_o   : one-cycle result-valid pulse
//   Bcd_o    : packed BCD result, units in [3:0]
//   Neg_o    : result is negative
//   Ovf_o    : magnitude was clamped to BCD_MAX
// master = client side, slave = converter side.
interface bin2bcd_seq_if #(
    parameter int DATA_W = 20
);
    import bin2bcd_pkg::*;

    logic                Start_i;
    logic [DATA_W-1:0]   Data_i;
    logic                Signed_i;
    logic                Busy_o;
    logic                Done_o;
    logic [4*NDIG-1:0]   Bcd_o;
    logic                Neg_o;
    logic                Ovf_o;

    modport master (
        output Start_i, Data_i, Signed_i,
        input  Busy_o, Done_o, Bcd_o, Neg_o, Ovf_o
    );

    modport slave (
        input  Start_i, Data_i, Signed_i,
        output Busy_o, Done_o, Bcd_o, Neg_o, Ovf_o
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational double-dabble corrector for one BCD digit: adds 3 when the
// digit is 5 or more so that the following left shift carries into the next
// digit correctly.
//   dig_in  : current BCD digit
//   dig_out : corrected digit, ready to be shifted
module bcd_digit_adj (
    input  logic [3:0] dig_in,
    output logic [3:0] dig_out
);

    assign dig_out = (dig_in >= 4'd5) ? (dig_in + 4'd3) : dig_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter feeding the six 7-segment digit
// decoders. Accepts one DATA_W-bit word (optionally two's complement),
// clamps its magnitude to 999999 and converts it with shift-and-add-3,
// one bit per clock. Sign is reported separately for the minus segment.
//   Clk_i : system clock
//   Rst_i : synchronous, active-high reset
//   bus   : request/result bundle (slave side), see bin2bcd_seq_if
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for Start_i; captures Data_i/Signed_i on accept
// ST_PREP  | derive sign and magnitude, clamp, clear scratch and counter
// ST_SHIFT | DATA_W double-dabble iterations; results register on last
// ST_DONE  | Done_o pulse, then back to idle
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  logic          Clk_i,
    input  logic          Rst_i,
    bin2bcd_seq_if.slave  bus
);

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   data_q;
    logic                signed_q;
    logic [DATA_W-1:0]   mag_q;
    logic                neg_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt;
    logic [4*NDIG-1:0]   bcd_q;

    logic [4*NDIG-1:0]   bcd_r;
    logic                neg_r;
    logic                ovf_r;

    logic                neg_c;
    logic [DATA_W-1:0]   mag_raw;
    logic                ovf_c;
    logic [DATA_W-1:0]   mag_c;

    logic [4*NDIG-1:0]          bcd_adj;
    logic [4*NDIG+DATA_W-1:0]   shift_cat;
    logic [4*NDIG-1:0]          bcd_shift;
    logic [DATA_W-1:0]          mag_shift;
    logic                       last_shift;

    // Two's-complement negate in DATA_W bits: the most negative input maps
    // to 2^(DATA_W-1), which still fits as an unsigned magnitude.
    assign neg_c   = signed_q & data_q[DATA_W-1];
    assign mag_raw = neg_c ? (~data_q + DATA_W'(1)) : data_q;
    assign ovf_c   = (32'(mag_raw) > 32'(BCD_MAX));
    assign mag_c   = ovf_c ? DATA_W'(BCD_MAX) : mag_raw;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_in  (bcd_q[4*g +: 4]),
            .dig_out (bcd_adj[4*g +: 4])
        );
    end

    // The clamp keeps the top digit <= 9, so nothing meaningful is lost off
    // the top of the scratch register.
    assign shift_cat  = {bcd_adj, mag_q} << 1;
    assign bcd_shift  = shift_cat[4*NDIG+DATA_W-1:DATA_W];
    assign mag_shift  = shift_cat[DATA_W-1:0];
    assign last_shift = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.Start_i) state_nxt = ST_PREP;
            ST_PREP:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            data_q   <= '0;
            signed_q <= 1'b0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            bcd_q    <= '0;
            bcd_r    <= '0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Start_i) begin
                        data_q   <= bus.Data_i;
                        signed_q <= bus.Signed_i;
                    end
                end
                ST_PREP: begin
                    mag_q <= mag_c;
                    neg_q <= neg_c;
                    ovf_q <= ovf_c;
                    bcd_q <= '0;
                    cnt   <= '0;
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_shift;
                    mag_q <= mag_shift;
                    cnt   <= cnt + CNT_W'(1);
                    // Results go out on the same edge that enters DONE.
                    if (last_shift) begin
                        bcd_r <= bcd_shift;
                        neg_r <= neg_q;
                        ovf_r <= ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy_o = (state != ST_IDLE);
    assign bus.Done_o = (state == ST_DONE);
    assign bus.Bcd_o  = bcd_r;
    assign bus.Neg_o  = neg_r;
    assign bus.Ovf_o  = ovf_r;

endmodule
